hsync_timing_gen: RTL and testbench

//  Parametrised horizontal timing generator: divides CLK10 into pixel and CPU clock enables and runs the line counter.

---
 rtl/hsync_timing_gen.sv | 135 +++++++++++++
 tb/tb_hsync_timing_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hsync_timing_gen.sv
// Horizontal timing generator: pixel/CPU clock enables, line counter, HBLANK/HSYNC/LINE_END decode.
// All outputs are registered from next-state values, so they are aligned with hcount; optional HSYNC_ADJ_EN adds per-line sync trim.
module hsync_timing_gen #(
    parameter int   CLK_DIV     = 2,
    parameter int   HW          = 9,
    parameter int   H_TOTAL     = 320,
    parameter int   H_VISIBLE   = 256,
    parameter int   HSYNC_START = 272,
    parameter int   HSYNC_WIDTH = 32,
    parameter logic HSYNC_POL   = 1'b1,
    parameter int   CPU_DIV     = 4
) (
    input  logic          CLK10,
    input  logic          RESET,
`ifdef HSYNC_ADJ_EN
    input  logic [3:0]    HSYNC_ADJ,
`endif
    output logic          PIX_CE,
    output logic          CPU_CE,
    output logic [HW-1:0] hcount,
    output logic          HBLANK,
    output logic          HSYNC,
    output logic          LINE_END
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = HW + 2;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] CPU_MASK = HW'(CPU_DIV - 1);
    localparam logic [SW-1:0] VIS_END  = SW'(H_VISIBLE);
    localparam logic [SW-1:0] SYNC_LEN = SW'(HSYNC_WIDTH);

    if (CLK_DIV < 1 || H_TOTAL < 1 || H_TOTAL > 2**HW || H_VISIBLE > H_TOTAL ||
        HSYNC_START < H_VISIBLE || HSYNC_WIDTH < 1 ||
        HSYNC_START + HSYNC_WIDTH > H_TOTAL || CPU_DIV < 1 ||
        (CPU_DIV & (CPU_DIV - 1)) != 0 || (H_TOTAL % CPU_DIV) != 0) begin : g_bad_params
        $error("hsync_timing_gen: illegal parameter set");
    end

    logic [DW-1:0] div_q, div_d;
    logic          pix_ce_q, pix_ce_d;
    logic          cpu_ce_q, cpu_ce_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic          hblank_q, hblank_d;
    logic          hsync_q, hsync_d;
    logic          line_end_q, line_end_d;
    logic          wrap;
    logic [SW-1:0] hc_ext;
    logic [SW-1:0] sync_lo;
    logic [SW-1:0] sync_hi;

`ifdef HSYNC_ADJ_EN
    if (HW < 3) begin : g_bad_adj_width
        $error("hsync_timing_gen: HW too small for HSYNC_ADJ");
    end

    localparam logic signed [SW-1:0] S_MIN = SW'(H_VISIBLE);
    localparam logic signed [SW-1:0] S_MAX = SW'(H_TOTAL - HSYNC_WIDTH);

    logic [3:0]           adj_q, adj_d;
    logic signed [SW-1:0] s_raw;

    // Trim is latched only at the wrap so a line never sees a sync position change mid-way.
    always_comb begin
        adj_d = wrap ? HSYNC_ADJ : adj_q;
        s_raw = SW'(HSYNC_START) + {{(SW-4){adj_q[3]}}, adj_q};
        if (s_raw < S_MIN) begin
            sync_lo = S_MIN;
        end else if (s_raw > S_MAX) begin
            sync_lo = S_MAX;
        end else begin
            sync_lo = s_raw;
        end
    end

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            adj_q <= '0;
        end else begin
            adj_q <= adj_d;
        end
    end
`else
    always_comb begin
        sync_lo = SW'(HSYNC_START);
    end
`endif

    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        pix_ce_d   = (div_d == DIV_LAST);
        wrap       = pix_ce_q && (hcount_q == H_LAST);
        hcount_d   = hcount_q;
        if (pix_ce_q) begin
            hcount_d = wrap ? '0 : hcount_q + HW'(1);
        end
        // Decode from the next count so every output lands on the same edge as hcount.
        hc_ext     = {2'b00, hcount_d};
        sync_hi    = sync_lo + SYNC_LEN;
        hblank_d   = (hc_ext >= VIS_END);
        hsync_d    = ((hc_ext >= sync_lo) && (hc_ext < sync_hi)) ? HSYNC_POL : ~HSYNC_POL;
        line_end_d = wrap;
        cpu_ce_d   = pix_ce_d && ((hcount_d & CPU_MASK) == CPU_MASK);
    end

    always_ff @(posedge CLK10) begin
        if (RESET) begin
            div_q      <= '0;
            pix_ce_q   <= 1'b0;
            cpu_ce_q   <= 1'b0;
            hcount_q   <= '0;
            hblank_q   <= 1'b0;
            hsync_q    <= ~HSYNC_POL;
            line_end_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pix_ce_q   <= pix_ce_d;
            cpu_ce_q   <= cpu_ce_d;
            hcount_q   <= hcount_d;
            hblank_q   <= hblank_d;
            hsync_q    <= hsync_d;
            line_end_q <= line_end_d;
        end
    end

    assign PIX_CE   = pix_ce_q;
    assign CPU_CE   = cpu_ce_q;
    assign hcount   = hcount_q;
    assign HBLANK   = hblank_q;
    assign HSYNC    = hsync_q;
    assign LINE_END = line_end_q;

endmodule

// File: tb/tb_hsync_timing_gen.sv
// Bench for hsync_timing_gen: default and small-line instances, mid-line reset; sync trim checks when HSYNC_ADJ_EN is defined.
module tb_hsync_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       d_pix, d_cpu, d_hb, d_hs, d_le;
    logic [8:0] d_hc;
    logic       s_pix, s_cpu, s_hb, s_hs, s_le;
    logic [4:0] s_hc;

`ifdef HSYNC_ADJ_EN
    logic [3:0] adj;
    logic [3:0] adj_c;
    logic       c_pix, c_cpu, c_hb, c_hs, c_le;
    logic [8:0] c_hc;
`endif

    hsync_timing_gen u_def (
        .CLK10     (clk),
        .RESET     (rst),
`ifdef HSYNC_ADJ_EN
        .HSYNC_ADJ (adj),
`endif
        .PIX_CE    (d_pix),
        .CPU_CE    (d_cpu),
        .hcount    (d_hc),
        .HBLANK    (d_hb),
        .HSYNC     (d_hs),
        .LINE_END  (d_le)
    );

    hsync_timing_gen #(
        .CLK_DIV(1), .HW(5), .H_TOTAL(20), .H_VISIBLE(16),
        .HSYNC_START(17), .HSYNC_WIDTH(2), .HSYNC_POL(1'b0), .CPU_DIV(4)
    ) u_sml (
        .CLK10     (clk),
        .RESET     (rst),
`ifdef HSYNC_ADJ_EN
        .HSYNC_ADJ (4'd0),
`endif
        .PIX_CE    (s_pix),
        .CPU_CE    (s_cpu),
        .hcount    (s_hc),
        .HBLANK    (s_hb),
        .HSYNC     (s_hs),
        .LINE_END  (s_le)
    );

`ifdef HSYNC_ADJ_EN
    hsync_timing_gen #(.H_VISIBLE(270)) u_clp (
        .CLK10     (clk),
        .RESET     (rst),
        .HSYNC_ADJ (adj_c),
        .PIX_CE    (c_pix),
        .CPU_CE    (c_cpu),
        .hcount    (c_hc),
        .HBLANK    (c_hb),
        .HSYNC     (c_hs),
        .LINE_END  (c_le)
    );
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef HSYNC_ADJ_EN
    // Skips to the next LINE_END, then records the hcount span of active HSYNC on both
    // trimmed instances for that whole line; optionally changes adj mid-line.
    task automatic scan_line(input int chg_at, input logic [3:0] chg_val,
                             output int f, output int l, output int cf, output int cl,
                             output int ok);
        int n;
        f = 999; l = -1; cf = 999; cl = -1; ok = 0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!d_le && n < 700);
        if (d_le) begin
            n = 0;
            do begin
                tick();
                n++;
                if (!d_le) begin
                    if (d_hs === 1'b1) begin
                        if (int'(d_hc) < f) f = int'(d_hc);
                        if (int'(d_hc) > l) l = int'(d_hc);
                    end
                    if (c_hs === 1'b1) begin
                        if (int'(c_hc) < cf) cf = int'(c_hc);
                        if (int'(c_hc) > cl) cl = int'(c_hc);
                    end
                    if (int'(d_hc) == chg_at) adj = chg_val;
                end
            end while (!d_le && n < 700);
            ok = d_le ? 1 : 0;
        end
    endtask
`endif

    int k, h, hs;
    int e_hc, e_pix, e_hb, e_hs, e_le, e_cpu;
    int es_hc, es_pix, es_hb, es_hs, es_le, es_cpu;
    int cpu_line, le_total, sle_total, found;
`ifdef HSYNC_ADJ_EN
    int f, l, cf, cl, ok;
`endif

    initial begin
        rst = 1'b1;
`ifdef HSYNC_ADJ_EN
        adj   = 4'd0;
        adj_c = 4'b1000;
`endif
        repeat (3) tick();

        chk("rst_hcount",   int'(d_hc),  0);
        chk("rst_hblank",   int'(d_hb),  0);
        chk("rst_hsync",    int'(d_hs),  0);
        chk("rst_pix_ce",   int'(d_pix), 0);
        chk("rst_cpu_ce",   int'(d_cpu), 0);
        chk("rst_line_end", int'(d_le),  0);
        chk("rst_sml_hsync", int'(s_hs), 1);
        chk("rst_sml_pix",   int'(s_pix), 0);

        e_hc = 0; e_pix = 0; e_hb = 0; e_hs = 0; e_le = 0; e_cpu = 0;
        es_hc = 0; es_pix = 0; es_hb = 0; es_hs = 0; es_le = 0; es_cpu = 0;
        cpu_line = 0; le_total = 0; sle_total = 0;

        rst = 1'b0;
        for (k = 1; k <= 1300; k++) begin
            tick();
            h  = (k / 2) % 320;
            hs = (k - 1) % 20;
            if (d_hc  !== 9'(h))                         e_hc++;
            if (d_pix !== (k % 2 == 1))                  e_pix++;
            if (d_hb  !== (h >= 256))                    e_hb++;
            if (d_hs  !== (h >= 272 && h <= 303))        e_hs++;
            if (d_le  !== (k % 640 == 0))                e_le++;
            if (d_cpu !== (k % 2 == 1 && h % 4 == 3))    e_cpu++;
            if (k <= 640 && d_cpu === 1'b1) cpu_line++;
            if (d_le === 1'b1) le_total++;

            if (s_hc  !== 5'(hs))                        es_hc++;
            if (s_pix !== 1'b1)                          es_pix++;
            if (s_hb  !== (hs >= 16))                    es_hb++;
            if (s_hs  !== !(hs >= 17 && hs <= 18))       es_hs++;
            if (s_le  !== (k > 1 && hs == 0))            es_le++;
            if (s_cpu !== (hs % 4 == 3))                 es_cpu++;
            if (s_le === 1'b1) sle_total++;
        end

        chk("def_hcount_seq",   e_hc,  0);
        chk("def_pix_ce_seq",   e_pix, 0);
        chk("def_hblank_seq",   e_hb,  0);
        chk("def_hsync_seq",    e_hs,  0);
        chk("def_line_end_seq", e_le,  0);
        chk("def_cpu_ce_seq",   e_cpu, 0);
        chk("def_cpu_per_line", cpu_line, 80);
        chk("def_line_end_cnt", le_total, 2);
        chk("sml_hcount_seq",   es_hc,  0);
        chk("sml_pix_stuck",    es_pix, 0);
        chk("sml_hblank_seq",   es_hb,  0);
        chk("sml_hsync_seq",    es_hs,  0);
        chk("sml_line_end_seq", es_le,  0);
        chk("sml_cpu_ce_seq",   es_cpu, 0);
        chk("sml_line_end_cnt", sle_total, 64);

        // Reset in the middle of the sync pulse.
        found = 0;
        for (int i = 0; i < 700 && found == 0; i++) begin
            tick();
            if (d_hc === 9'd280) found = 1;
        end
        chk("mid_found_280", found, 1);
        chk("mid_pre_hsync", int'(d_hs), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_hcount",   int'(d_hc), 0);
        chk("mid_hsync",    int'(d_hs), 0);
        chk("mid_hblank",   int'(d_hb), 0);
        chk("mid_line_end", int'(d_le), 0);
        tick();
        chk("mid_hcount_2",   int'(d_hc),  0);
        chk("mid_line_end_2", int'(d_le),  0);
        chk("mid_pix_ce_2",   int'(d_pix), 1);

`ifdef HSYNC_ADJ_EN
        adj = 4'd7;
        scan_line(-1, 4'd0, f, l, cf, cl, ok);
        chk("adj_p7_found", ok, 1);
        chk("adj_p7_first", f, 279);
        chk("adj_p7_last",  l, 310);
        chk("clamp_vis_first", cf, 270);
        chk("clamp_vis_last",  cl, 301);

        adj = 4'b1000;
        scan_line(-1, 4'd0, f, l, cf, cl, ok);
        chk("adj_m8_found", ok, 1);
        chk("adj_m8_first", f, 264);
        chk("adj_m8_last",  l, 295);

        scan_line(290, 4'd7, f, l, cf, cl, ok);
        chk("adj_midline_found", ok, 1);
        chk("adj_midline_first", f, 264);
        chk("adj_midline_last",  l, 295);

        scan_line(-1, 4'd0, f, l, cf, cl, ok);
        chk("adj_nextline_found", ok, 1);
        chk("adj_nextline_first", f, 279);
        chk("adj_nextline_last",  l, 310);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
